// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory/MMIO target for the CPU memory port.
// Decodes CPU word addresses into on-chip RAM, a TX byte FIFO, a status
// register, an optional cycle counter and the read-only boot-vector word.
// Optional feature: define MEM_BUS_CYCLE_COUNTER_EN to build the CYCLES counter.
module mem_bus_ctrl #(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [29:0] W_TXDATA = 30'h3FFF_FC00;
  localparam logic [29:0] W_STATUS = 30'h3FFF_FC01;
  localparam logic [29:0] W_CYCLES = 30'h3FFF_FC02;
  localparam logic [29:0] W_BOOT   = 30'h3FFF_FFFF;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [31:0]   BOOT_WORD = {RESET_VECTOR[24:2], 3'b000, 6'h02};

  logic [29:0]   word;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  logic hit_ram, hit_tx, hit_stat, hit_cyc, hit_boot, hit_none;
  logic wr_en;

  logic [31:0] ram [RAM_WORDS];

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, empty, push, pop, push_ok;

  logic ovf, buserr;
  logic ovf_set, buserr_set, stat_wr;

  logic [31:0] cyc_rd;

  assign word             = cpu_addr[31:2];
  assign ram_idx          = cpu_addr[AW+1:2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Address decode; anything not matched is an unmapped access
  always_comb begin
    hit_ram  = (cpu_addr[31:AW+2] == '0);
    hit_tx   = (word == W_TXDATA);
    hit_stat = (word == W_STATUS);
    hit_cyc  = (word == W_CYCLES);
    hit_boot = (word == W_BOOT);
    hit_none = !(hit_ram || hit_tx || hit_stat || hit_cyc || hit_boot);
  end

  // Writes of every kind are suppressed while reset is held
  assign wr_en = cpu_we && !reset;

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && hit_ram) begin
      ram[ram_idx] <= cpu_wdata;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign push    = wr_en && hit_tx;
  assign pop     = tx_valid && tx_ready;
  assign push_ok = push && (!full || pop);
  assign tx_data = fifo_mem[rd_ptr];

  // Next FIFO occupancy; a push into a full FIFO only lands alongside a pop
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= cpu_wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and registered valid; reset drops all contents
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tx_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nxt;
      tx_valid <= (count_nxt != '0);
    end
  end

  assign ovf_set    = push && full && !pop;
  assign buserr_set = wr_en && hit_none;
  assign stat_wr    = wr_en && hit_stat;

  // Sticky error bits; a new event on the same edge beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf    <= 1'b0;
      buserr <= 1'b0;
    end else begin
      if (ovf_set)                      ovf <= 1'b1;
      else if (stat_wr && cpu_wdata[2]) ovf <= 1'b0;
      if (buserr_set)                   buserr <= 1'b1;
      else if (stat_wr && cpu_wdata[3]) buserr <= 1'b0;
    end
  end

`ifdef MEM_BUS_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end

  assign cyc_rd = cycles;
`else
  assign cyc_rd = '0;
`endif

  // Zero-latency read mux
  always_comb begin
    cpu_rdata = '0;
    if (hit_ram)       cpu_rdata = ram[ram_idx];
    else if (hit_stat) cpu_rdata = {28'b0, buserr, ovf, full, empty};
    else if (hit_cyc)  cpu_rdata = cyc_rd;
    else if (hit_boot) cpu_rdata = BOOT_WORD;
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: self-checking bench for mem_bus_ctrl (RESET_VECTOR = 0x100).
// Bus reads are checked through a read scoreboard; TX bytes are queued on push
// and checked by a consumer monitor when the DUT hands them over.
module tb_mem_bus_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam logic [29:0] TX_WORD = 30'h3FFF_FC00;
  localparam logic [31:0] A_TX   = 32'hFFFF_F000;
  localparam logic [31:0] A_STAT = 32'hFFFF_F004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_F008;
  localparam logic [31:0] A_BOOT = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [15];

  mem_bus_ctrl #(
    .RAM_WORDS(1024),
    .FIFO_DEPTH(DEPTH),
    .RESET_VECTOR(32'h0000_0100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive after the edge, compare the combinational read mid-cycle
  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic rdy, input logic chk, input logic [31:0] e,
                      input string nm);
    logic [31:0] ev;
    @(posedge clk);
    #2;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = w;
    tx_ready  = rdy;
    if (w && a[31:2] == TX_WORD) begin
      if (tx_q.size() < DEPTH || (rdy && tx_q.size() > 0)) tx_q.push_back(d[7:0]);
    end
    if (chk) rd_q.push_back(e);
    @(negedge clk);
    if (chk) begin
      ev = rd_q.pop_front();
      check(nm, cpu_rdata, ev);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    xact(a, 32'h0, 1'b0, 1'b0, 1'b1, e, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xact(a, d, 1'b1, 1'b0, 1'b0, 32'h0, "wr");
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) xact(A_BOOT, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_8002, "drain_boot");
  endtask

  // Consumer: every handshake must deliver the oldest byte still expected
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_extra: got byte 0x%02h expected none", tx_data);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0, c1;
    vt[0]  = '{32'h0000_0014, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[3]  = '{32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[4]  = '{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[5]  = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vt[7]  = '{32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0};
    vt[8]  = '{32'h8000_0000, 32'h0,         1'b0, 1'b1, 32'h0};
    vt[9]  = '{A_TX,          32'h0,         1'b0, 1'b1, 32'h0};
    vt[10] = '{A_BOOT,        32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vt[11] = '{32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 32'h0000_8002};
    vt[12] = '{A_CYC,         32'h0000_AAAA, 1'b1, 1'b0, 32'h0};
    vt[13] = '{32'hFFFF_F00C, 32'h0,         1'b0, 1'b1, 32'h0};
    vt[14] = '{A_STAT,        32'h0,         1'b0, 1'b1, 32'h0000_0001};

    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
`ifdef MEM_BUS_CYCLE_COUNTER_EN
    rd(A_CYC, 32'h1, "rst_cycles");
`else
    rd(A_CYC, 32'h0, "rst_cycles");
`endif
    rd(A_BOOT, 32'h0000_8002, "boot_word");
    rd(A_STAT, 32'h0000_0001, "rst_status");

    // Decode and RAM vectors
    for (int i = 0; i < 15; i++)
      xact(vt[i].addr, vt[i].wdata, vt[i].we, 1'b0, vt[i].chk, vt[i].exp, $sformatf("vec%0d", i));

    // Read-during-write shows old word, new word next cycle
    xact(32'h10, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, "rdw_old");
    rd(32'h10, 32'h1111_1111, "rdw_new");

    // FIFO: three bytes, held, then drained in order
    wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43);
    rd(A_STAT, 32'h0, "abc_status");
    check("abc_head", {24'h0, tx_data}, 32'h41);
    check("abc_valid", {31'h0, tx_valid}, 32'h1);
    drain(3);
    rd(A_STAT, 32'h1, "abc_empty");

    // Overflow: DEPTH+1 pushes, last dropped
    for (int k = 0; k <= DEPTH; k++) wr(A_TX, 32'h10 + 32'(k));
    rd(A_STAT, 32'h6, "ovf_status");
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h2, "ovf_cleared");
    drain(DEPTH);
    rd(A_STAT, 32'h1, "ovf_drained");

    // Full FIFO: push and pop on the same edge
    for (int k = 0; k < DEPTH; k++) wr(A_TX, 32'h80 + 32'(k));
    xact(A_TX, 32'h99, 1'b1, 1'b1, 1'b0, 32'h0, "full_pushpop");
    rd(A_STAT, 32'h2, "full_pushpop_status");
    drain(DEPTH);
    rd(A_STAT, 32'h1, "full_drained");

    // Unmapped writes set buserr and leave RAM alone
    wr(32'h0, 32'hA5A5_A5A5);
    wr(32'h8000_0000, 32'hFFFF_FFFF);
    wr(32'h0000_1000, 32'h0BAD_0BAD);
    rd(32'h0, 32'hA5A5_A5A5, "buserr_ram");
    rd(A_STAT, 32'h9, "buserr_status");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h1, "buserr_cleared");

    // Reset mid-operation: FIFO dropped, write suppressed
    wr(32'h20, 32'h55);
    wr(A_TX, 32'h71); wr(A_TX, 32'h72);
    @(posedge clk);
    #2;
    reset = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h66; cpu_we = 1'b1; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    #1 reset = 1'b0; cpu_we = 1'b0;
    tx_q.delete();
    rd(32'h20, 32'h55, "midrst_ram");
    rd(A_STAT, 32'h1, "midrst_status");

    // Cycle counter spacing
    xact(A_CYC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "cyc0");
    c0 = cpu_rdata;
    for (int k = 0; k < 9; k++) xact(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "idle");
    xact(A_CYC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "cyc1");
    c1 = cpu_rdata;
`ifdef MEM_BUS_CYCLE_COUNTER_EN
    check("cycles_delta", c1 - c0, 32'd10);
`else
    check("cycles_c0", c0, 32'h0);
    check("cycles_c1", c1, 32'h0);
`endif

    check("tx_q_empty", 32'(tx_q.size()), 32'h0);
    check("end_tx_valid", {31'h0, tx_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
